// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants and types for the MMIO responder.
//   OFF_*      : byte offsets of the registers relative to BASE_ADDR.
//   funct3_e   : RV32I load/store size codes. Bit 3 marks a store, so the
//                load and store codes that share a funct3 value stay
//                distinct enum members. Compare against {is_store, funct3}.
//   PWM_WIDTH  : width of the duty bytes and the shared PWM counter.
//   sext8/16   : sign-extension helpers for LB/LH.
package mmio_pkg;

    localparam logic [31:0] OFF_MICROS = 32'd0;
    localparam logic [31:0] OFF_MILLIS = 32'd4;
    localparam logic [31:0] OFF_DUTY   = 32'd8;

    localparam int PWM_WIDTH = 8;

    typedef enum logic [3:0] {
        LB  = 4'b0_000,
        LH  = 4'b0_001,
        LW  = 4'b0_010,
        LBU = 4'b0_100,
        LHU = 4'b0_101,
        SB  = 4'b1_000,
        SH  = 4'b1_001,
        SW  = 4'b1_010
    } funct3_e;

    function automatic logic [31:0] sext8(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] h);
        return {{16{h[15]}}, h};
    endfunction

endpackage

// File: rtl/mmio_responder_pwm_channel.sv
// pwm_channel: one PWM output stage.
//   duty_i : duty byte for this channel
//   cnt_i  : shared PWM counter value
//   pwm_o  : high while cnt_i < duty_i
// The comparison is all this stage does; the caller decides what counter
// value to present (free-running counter, or a constant for the
// threshold-only build).
module pwm_channel
    import mmio_pkg::*;
(
    input  logic [PWM_WIDTH-1:0] duty_i,
    input  logic [PWM_WIDTH-1:0] cnt_i,
    output logic                 pwm_o
);

    assign pwm_o = (cnt_i < duty_i);

endmodule

// File: rtl/mmio_responder.sv
// mmio_responder: memory-mapped timebase and PWM peripheral.
//   Registers (word addresses from BASE_ADDR):
//     +0 MICROS (RO) microseconds since reset
//     +4 MILLIS (RO) milliseconds since reset
//     +8 DUTY   (RW) [7:0] led, [15:8] red, [23:16] green, [31:24] blue
// Ports:
//   clk, reset (synchronous, active low)
//   write_mem, funct3, write_address, write_data : CPU store port
//   read_address, read_data                      : CPU load port (combinational)
//   led, red, green, blue                        : PWM outputs
// Build option: MMIO_PWM_EN. Defined -> 8-bit free-running PWM per channel.
//   Undefined -> no PWM counter; each output is bit 7 of its duty byte.
module mmio_responder
    import mmio_pkg::*;
#(
    parameter int          CLK_HZ    = 12_000_000,
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FFF4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_mem,
    input  logic [2:0]  funct3,
    input  logic [31:0] write_address,
    input  logic [31:0] write_data,
    input  logic [31:0] read_address,
    output logic [31:0] read_data,
    output logic        led,
    output logic        red,
    output logic        green,
    output logic        blue
);

    localparam int DIV = CLK_HZ / 1_000_000;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    // Word-address tags compared against address[31:2].
    localparam logic [29:0] TAG_MICROS = 30'((BASE_ADDR + OFF_MICROS) >> 2);
    localparam logic [29:0] TAG_MILLIS = 30'((BASE_ADDR + OFF_MILLIS) >> 2);
    localparam logic [29:0] TAG_DUTY   = 30'((BASE_ADDR + OFF_DUTY) >> 2);

    logic [PW-1:0] presc_q, presc_d;
    logic [9:0]    sub_q, sub_d;
    logic [31:0]   micros_q, micros_d;
    logic [31:0]   millis_q, millis_d;
    logic [31:0]   duty_q, duty_d;
    logic          us_tick, ms_tick;

    // ---------------- timebase ----------------
    always_comb begin
        us_tick  = (presc_q == PRESC_MAX);
        ms_tick  = us_tick && (sub_q == 10'd999);
        presc_d  = us_tick ? '0 : presc_q + 1'b1;
        micros_d = us_tick ? micros_q + 32'd1 : micros_q;
        sub_d    = sub_q;
        if (us_tick) begin
            sub_d = ms_tick ? 10'd0 : sub_q + 10'd1;
        end
        millis_d = ms_tick ? millis_q + 32'd1 : millis_q;
    end

    // ---------------- stores ----------------
    logic wr_hit_duty;
    assign wr_hit_duty = (write_address[31:2] == TAG_DUTY);

    always_comb begin
        duty_d = duty_q;
        if (write_mem && wr_hit_duty) begin
            case ({1'b1, funct3})
                SB: duty_d[{write_address[1:0], 3'b000} +: 8] = write_data[7:0];
                SH: if (!write_address[0]) begin
                        duty_d[{write_address[1], 4'b0000} +: 16] = write_data[15:0];
                    end
                SW: if (write_address[1:0] == 2'b00) begin
                        duty_d = write_data;
                    end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            presc_q  <= '0;
            sub_q    <= '0;
            micros_q <= '0;
            millis_q <= '0;
            duty_q   <= '0;
        end else begin
            presc_q  <= presc_d;
            sub_q    <= sub_d;
            micros_q <= micros_d;
            millis_q <= millis_d;
            duty_q   <= duty_d;
        end
    end

    // ---------------- loads ----------------
    // Reads see registered state only, so a same-cycle store to DUTY
    // returns the old value.
    logic [31:0] rd_word;
    logic        rd_mapped;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        rd_word   = '0;
        rd_mapped = 1'b1;
        if (read_address[31:2] == TAG_MICROS) begin
            rd_word = micros_q;
        end else if (read_address[31:2] == TAG_MILLIS) begin
            rd_word = millis_q;
        end else if (read_address[31:2] == TAG_DUTY) begin
            rd_word = duty_q;
        end else begin
            rd_mapped = 1'b0;
        end
        rd_byte = rd_word[{read_address[1:0], 3'b000} +: 8];
        rd_half = rd_word[{read_address[1], 4'b0000} +: 16];

        read_data = '0;
        if (rd_mapped) begin
            case ({1'b0, funct3})
                LB:  read_data = sext8(rd_byte);
                LBU: read_data = {24'd0, rd_byte};
                LH:  if (!read_address[0]) read_data = sext16(rd_half);
                LHU: if (!read_address[0]) read_data = {16'd0, rd_half};
                LW:  if (read_address[1:0] == 2'b00) read_data = rd_word;
                default: read_data = '0;
            endcase
        end
    end

    // ---------------- PWM ----------------
    logic [PWM_WIDTH-1:0] pwm_cnt;

`ifdef MMIO_PWM_EN
    logic [PWM_WIDTH-1:0] pwm_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
        end
    end

    assign pwm_cnt = pwm_cnt_q;
`else
    // With the counter held at 0x7F, "cnt < duty" is exactly duty[7],
    // so the same channel stage yields the MSB of the registered duty byte.
    assign pwm_cnt = {1'b0, {(PWM_WIDTH-1){1'b1}}};
`endif

    pwm_channel u_led   (.duty_i(duty_q[7:0]),   .cnt_i(pwm_cnt), .pwm_o(led));
    pwm_channel u_red   (.duty_i(duty_q[15:8]),  .cnt_i(pwm_cnt), .pwm_o(red));
    pwm_channel u_green (.duty_i(duty_q[23:16]), .cnt_i(pwm_cnt), .pwm_o(green));
    pwm_channel u_blue  (.duty_i(duty_q[31:24]), .cnt_i(pwm_cnt), .pwm_o(blue));

endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder: directed self-checking bench for mmio_responder.
// Expected values are hand-computed from the register map; the microsecond
// and PWM phases are derived from a bench-side cycle counter.
module tb_mmio_responder;

    localparam logic [31:0] BASE   = 32'hFFFF_FFF4;
    localparam logic [31:0] A_US   = BASE;
    localparam logic [31:0] A_MS   = BASE + 32'd4;
    localparam logic [31:0] A_DUTY = BASE + 32'd8;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

`ifdef MMIO_PWM_EN
    localparam bit PWM_EN = 1'b1;
`else
    localparam bit PWM_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        write_mem;
    logic [2:0]  funct3;
    logic [31:0] write_address;
    logic [31:0] write_data;
    logic [31:0] read_address;
    logic [31:0] read_data;
    logic        led, red, green, blue;

    int n_checks = 0;
    int n_errors = 0;
    int cyc;
    logic [31:0] exp_q[$];

    mmio_responder #(
        .CLK_HZ    (12_000_000),
        .BASE_ADDR (BASE)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .write_mem     (write_mem),
        .funct3        (funct3),
        .write_address (write_address),
        .write_data    (write_data),
        .read_address  (read_address),
        .read_data     (read_data),
        .led           (led),
        .red           (red),
        .green         (green),
        .blue          (blue)
    );

    // ---------------- clock / reset-relative cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // ---------------- drivers (called just after a falling edge) ----------------
    task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
        write_mem     = 1'b1;
        funct3        = f3;
        write_address = addr;
        write_data    = data;
        @(posedge clk);
        @(negedge clk);
        write_mem     = 1'b0;
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, output logic [31:0] data);
        funct3       = f3;
        read_address = addr;
        #1;
        data = read_data;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Load vectors with DUTY = 32'h80FF_0040.
    localparam int NLV = 13;
    logic [2:0]  lv_f3   [NLV] = '{F_W, F_B, F_B, F_B, F_BU, F_B, F_H, F_H, F_HU, F_H, F_W, F_B, F_W};
    logic [31:0] lv_addr [NLV] = '{A_DUTY, A_DUTY, A_DUTY + 1, A_DUTY + 2, A_DUTY + 2, A_DUTY + 3,
                                   A_DUTY, A_DUTY + 2, A_DUTY + 2, A_DUTY + 1, A_DUTY + 2,
                                   32'hFFFF_FFF0, 32'h0000_0008};
    logic [31:0] lv_exp  [NLV] = '{32'h80FF_0040, 32'h0000_0040, 32'h0000_0000, 32'hFFFF_FFFF,
                                   32'h0000_00FF, 32'hFFFF_FF80, 32'h0000_0040, 32'hFFFF_80FF,
                                   32'h0000_80FF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
                                   32'h0000_0000};

    initial begin
        logic [31:0] v;
        int cnt[4];
        int exp_cnt[4];
        int n;

        reset = 1'b0;
        write_mem = 1'b0;
        funct3 = 3'b000;
        write_address = '0;
        write_data = '0;
        read_address = '0;

        // Reset held for three edges, then released.
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        check("rst_outputs", {28'd0, led, red, green, blue}, 32'd0);
        do_load(F_W, A_US, v);   check("rst_micros", v, 32'd0);
        do_load(F_W, A_MS, v);   check("rst_millis", v, 32'd0);
        do_load(F_W, A_DUTY, v); check("rst_duty", v, 32'd0);

        // Timebase: 12 clocks per microsecond.
        repeat (11999) @(posedge clk);
        @(negedge clk);
        do_load(F_W, A_US, v); check("micros_11999", v, 32'd999);
        do_load(F_W, A_MS, v); check("millis_11999", v, 32'd0);
        tick(1);
        do_load(F_W, A_US, v); check("micros_12000", v, 32'd1000);
        do_load(F_W, A_MS, v); check("millis_12000", v, 32'd1);

        // Word store and load extension/alignment table.
        do_store(F_W, A_DUTY, 32'h80FF_0040);
        for (int i = 0; i < NLV; i++) begin
            exp_q.push_back(lv_exp[i]);
            do_load(lv_f3[i], lv_addr[i], v);
            check($sformatf("load_vec%0d", i), v, exp_q.pop_front());
        end

        // PWM duty: led 0x40, red 0x00, green 0xFF, blue 0x80.
        cnt = '{0, 0, 0, 0};
        for (int i = 0; i < 256; i++) begin
            @(posedge clk);
            @(negedge clk);
            cnt[0] += int'(led);
            cnt[1] += int'(red);
            cnt[2] += int'(green);
            cnt[3] += int'(blue);
        end
        if (PWM_EN) exp_cnt = '{64, 0, 255, 128};
        else        exp_cnt = '{0, 0, 256, 256};
        check("pwm_led",   cnt[0], exp_cnt[0]);
        check("pwm_red",   cnt[1], exp_cnt[1]);
        check("pwm_green", cnt[2], exp_cnt[2]);
        check("pwm_blue",  cnt[3], exp_cnt[3]);

        // Byte store into the red lane, then halfword store into the upper lanes.
        do_store(F_B, A_DUTY + 1, 32'h1234_56C0);
        do_load(F_B, A_DUTY + 1, v);  check("sb_lb", v, 32'hFFFF_FFC0);
        do_load(F_BU, A_DUTY + 1, v); check("sb_lbu", v, 32'h0000_00C0);
        do_load(F_W, A_DUTY, v);      check("sb_word", v, 32'h80FF_C040);
        do_store(F_H, A_DUTY + 2, 32'h9999_ABCD);
        do_load(F_W, A_DUTY, v);      check("sh_word", v, 32'hABCD_C040);

        // Stores that must be ignored.
        do_store(F_H, A_DUTY + 1, 32'h0000_1111);
        do_store(F_W, A_DUTY + 1, 32'h2222_2222);
        do_store(3'b011, A_DUTY, 32'h3333_3333);
        do_store(3'b100, A_DUTY, 32'h4444_4444);
        do_store(F_W, 32'hFFFF_FFF0, 32'h5555_5555);
        write_address = A_DUTY; write_data = 32'h6666_6666; funct3 = F_W; // write_mem low
        tick(1);
        do_load(F_W, A_DUTY, v); check("ignored_stores", v, 32'hABCD_C040);
        do_store(F_W, A_US, 32'h7777_7777);
        do_load(F_W, A_US, v);   check("sw_micros_ignored", v, 32'(cyc / 12));
        do_store(F_W, A_MS, 32'h7777_7777);
        do_load(F_W, A_MS, v);   check("sw_millis_ignored", v, 32'(cyc / 12000));

        // Load and store to DUTY in the same cycle.
        write_mem = 1'b1; funct3 = F_W; write_address = A_DUTY; write_data = 32'h1122_3344;
        read_address = A_DUTY;
        #1;
        check("rw_same_cycle_old", read_data, 32'hABCD_C040);
        @(posedge clk);
        @(negedge clk);
        write_mem = 1'b0;
        do_load(F_W, A_DUTY, v); check("rw_after_new", v, 32'h1122_3344);

        // MICROS wrap: align to just after a microsecond tick, then force.
        n = 0;
        while ((cyc % 12) != 0 && n < 24) begin
            tick(1);
            n++;
        end
        check("align_bound", 32'((cyc % 12) == 0), 32'd1);
        force dut.micros_q = 32'hFFFF_FFFF;
        tick(1);
        release dut.micros_q;
        do_load(F_W, A_US, v); check("micros_forced", v, 32'hFFFF_FFFF);
        n = 0;
        do begin
            tick(1);
            n++;
            do_load(F_W, A_US, v);
        end while (v == 32'hFFFF_FFFF && n < 30);
        check("micros_wrap", v, 32'd0);
        check("micros_wrap_cycles", n, 32'd11);

        // Reset mid-PWM with all duties at full scale.
        do_store(F_W, A_DUTY, 32'hFFFF_FFFF);
        tick(5);
        v = (PWM_EN && (cyc % 256) == 255) ? 32'd0 : 32'd1;
        check("full_duty_led", {31'd0, led}, v);
        check("full_duty_blue", {31'd0, blue}, v);
        reset = 1'b0;
        write_mem = 1'b1; funct3 = F_W; write_address = A_DUTY; write_data = 32'h1234_5678;
        read_address = A_DUTY;
        @(posedge clk);
        #1;
        check("midrst_outputs", {28'd0, led, red, green, blue}, 32'd0);
        check("midrst_duty", read_data, 32'd0);
        @(negedge clk);
        write_mem = 1'b0;
        reset = 1'b1;
        tick(1);
        do_load(F_W, A_DUTY, v); check("postrst_duty", v, 32'd0);
        do_load(F_W, A_US, v);   check("postrst_micros", v, 32'd0);
        do_load(F_W, A_MS, v);   check("postrst_millis", v, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Run-time bound.
    initial begin
        #5_000_000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
